mult_div_unit: RTL and testbench

//  Multi-cycle multiply/divide unit beside the ALU in the EX stage; owns HI/LO.

---
 rtl/mult_div_unit_pkg.sv | 29 ++
 rtl/mult_div_unit.sv | 116 +++++++++++
 tb/tb_mult_div_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes, FSM states and default cycle counts for the multiply/divide unit.
// Cycle-count helpers live here so the top can size its down-counter.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } mdop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO, plus single-cycle MTHI/MTLO.
// Latency: result visible N cycles after the launch edge (N = MULT_CYCLES or DIV_CYCLES).
// Backpressure: busy high while an op is in flight; start during busy is dropped.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [31:0]     res_hi, res_lo;
    logic            res_keep;

    logic [63:0]     prod;
    logic            div_signed, a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, den, uq, ur, quo, rem;

    // Whole result is formed at launch; the counter only models the pipeline delay.
    always_comb begin
        prod = 64'd0;
        if (mdop == MD_MULT)
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        else
            prod = {32'd0, A} * {32'd0, B};

        div_signed = (mdop == MD_DIV);
        a_neg      = div_signed & A[31];
        b_neg      = div_signed & B[31];
        a_mag      = a_neg ? (32'd0 - A) : A;
        b_mag      = b_neg ? (32'd0 - B) : B;
        den        = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uq         = a_mag / den;
        ur         = a_mag % den;
        // Magnitude divide then sign fix-up: quotient truncates toward zero,
        // remainder follows the dividend; 0x80000000 / -1 falls out as 0x80000000.
        quo        = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem        = a_neg ? (32'd0 - ur) : ur;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (mdop == MD_MULT || mdop == MD_MULTU)
                        state_nxt = S_MUL;
                    else if (mdop == MD_DIV || mdop == MD_DIVU)
                        state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CW'(1))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            res_keep <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                if (start) begin
                    case (mdop)
                        MD_MULT, MD_MULTU: begin
                            res_hi   <= prod[63:32];
                            res_lo   <= prod[31:0];
                            res_keep <= 1'b0;
                            cnt      <= CW'(MULT_CYCLES);
                        end
                        MD_DIV, MD_DIVU: begin
                            res_hi   <= rem;
                            res_lo   <= quo;
                            res_keep <= (B == 32'd0);
                            cnt      <= CW'(DIV_CYCLES);
                        end
                        MD_MTHI: hi <= A;
                        MD_MTLO: lo <= A;
                        default: ;
                    endcase
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1) && !res_keep) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO expectations.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] cur_hi, cur_lo;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one multi-cycle op, check busy and unchanged HI/LO for n cycles, then the commit.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1; mdop = op; A = a; B = b;
        tick();
        start = 1'b0; A = ~a; B = ~b;
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_hold_hi"}, hi, cur_hi);
            check({tag, "_hold_lo"}, lo, cur_lo);
            tick();
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] ehi, input logic [31:0] elo);
        start = 1'b1; mdop = op; A = a; B = 32'd0;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mdop = 3'd0; A = 32'd0; B = 32'd0;
        cur_hi = 32'd0; cur_lo = 32'd0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_hi", hi, 32'd0);
            check("rst_lo", lo, 32'd0);
            tick();
        end

        run_op("mult",  3'b000, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div",   3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'b011, 32'd7, 32'd2, 10, 32'd1, 32'd3);

        mt_op("mthi", 3'b100, 32'h1234_5678, 32'h1234_5678, cur_lo);
        mt_op("mtlo", 3'b101, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("div0", 3'b010, 32'd100, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);

        // Undefined opcode must not move anything.
        mt_op("undef", 3'b110, 32'hDEAD_BEEF, cur_hi, cur_lo);

        // MULT with a stray DIVU issued on busy cycle 2 and operands changing mid-op.
        start = 1'b1; mdop = 3'b000; A = 32'h0001_0000; B = 32'h0001_0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ovl_busy", {31'd0, busy}, 32'd1);
            if (i == 1) begin
                start = 1'b1; mdop = 3'b011; A = 32'd100; B = 32'd3;
            end else begin
                start = 1'b0; A = 32'h5555_5555;
            end
            tick();
        end
        start = 1'b0;
        check("ovl_done", {31'd0, busy}, 32'd0);
        check("ovl_hi", hi, 32'd1);
        check("ovl_lo", lo, 32'd0);
        tick();
        check("ovl_norelaunch", {31'd0, busy}, 32'd0);
        cur_hi = 32'd1; cur_lo = 32'd0;

        run_op("divovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // Reset on busy cycle 4 of a DIV: abort, clear, no late commit.
        start = 1'b1; mdop = 3'b010; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("abort_busy0", {31'd0, busy}, 32'd0);
            check("abort_hi", hi, 32'd0);
            check("abort_lo", lo, 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
